aes_row_shift_pipe: RTL and testbench

Parametrised, elastic ShiftRows/InvShiftRows stage for the AES/Rijndael cipher datapath. It accepts one state per beat on a valid/ready handshake and applies the Rijndael row rotation for a configurable column count (Nb = 4, 6, 8). It passes the result through a configurable-depth registered pipeline with full backpressure. It sits between the SubBytes and MixColumns stages of the round datapath and serves both the encrypt and decrypt paths.

---
 rtl/aes_row_shift_pipe.sv | 136 +++++++++++++
 tb/tb_aes_row_shift_pipe.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_row_shift_pipe.sv
// aes_row_shift_pipe: elastic AES ShiftRows/InvShiftRows stage, Nb = 4/6/8, PIPE_DEPTH register stages.
// Optional macro ROW_SHIFT_INV_EN builds the per-beat inverse path; rev 1.0.
`default_nettype none

module aes_row_shift_pipe #(
   parameter int NB         = 4,
   parameter int PIPE_DEPTH = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [32*NB-1:0]    in_data,
   input  logic                in_inv,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [32*NB-1:0]    out_data,
   output logic                out_inv,
   output logic                busy
);

   localparam int STATE_W = 32 * NB;

   if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("aes_row_shift_pipe: NB must be 4, 6 or 8");
   end
   if (PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_depth
      $error("aes_row_shift_pipe: PIPE_DEPTH must be 1..4");
   end

   logic [STATE_W-1:0] fwd_state;
   logic [STATE_W-1:0] xform_state;
   logic               xform_inv;

   // Byte (r, c) sits at in_data[STATE_W-1-8*(r+4c) -: 8]; byte 0 is the MSB byte.
   for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int SH = (r == 0) ? 0 :
                          (r == 1) ? 1 :
                          (r == 2) ? ((NB == 8) ? 3 : 2) :
                                     ((NB == 8) ? 4 : 3);
      for (genvar c = 0; c < NB; c++) begin : g_col
         localparam int SRC_F = (c + SH) % NB;
         assign fwd_state[STATE_W-1-8*(r+4*c) -: 8] = in_data[STATE_W-1-8*(r+4*SRC_F) -: 8];
      end
   end

`ifdef ROW_SHIFT_INV_EN
   logic [STATE_W-1:0] inv_state;

   for (genvar r = 0; r < 4; r++) begin : g_irow
      localparam int SH = (r == 0) ? 0 :
                          (r == 1) ? 1 :
                          (r == 2) ? ((NB == 8) ? 3 : 2) :
                                     ((NB == 8) ? 4 : 3);
      for (genvar c = 0; c < NB; c++) begin : g_icol
         localparam int SRC_I = (c + NB - SH) % NB;
         assign inv_state[STATE_W-1-8*(r+4*c) -: 8] = in_data[STATE_W-1-8*(r+4*SRC_I) -: 8];
      end
   end

   assign xform_state = in_inv ? inv_state : fwd_state;
   assign xform_inv   = in_inv;
`else
   logic unused_inv;

   assign unused_inv  = in_inv;
   assign xform_state = fwd_state;
   assign xform_inv   = 1'b0;
`endif

   logic [PIPE_DEPTH-1:0] valid_q, valid_d;
   logic [PIPE_DEPTH-1:0] inv_q, inv_d;
   logic [STATE_W-1:0]    data_q [PIPE_DEPTH];
   logic [STATE_W-1:0]    data_d [PIPE_DEPTH];
   logic [PIPE_DEPTH-1:0] load;

   // A stage can take new contents iff some stage at or after it is empty, or the tail drains.
   always_comb begin
      logic all_full;
      load = '0;
      for (int k = 0; k < PIPE_DEPTH; k++) begin
         all_full = 1'b1;
         for (int j = k; j < PIPE_DEPTH; j++) begin
            all_full = all_full & valid_q[j];
         end
         load[k] = ~all_full | out_ready;
      end
   end

   always_comb begin
      valid_d = valid_q;
      inv_d   = inv_q;
      data_d  = data_q;
      if (load[0]) begin
         valid_d[0] = in_valid;
         if (in_valid) begin
            data_d[0] = xform_state;
            inv_d[0]  = xform_inv;
         end
      end
      for (int k = 1; k < PIPE_DEPTH; k++) begin
         if (load[k]) begin
            valid_d[k] = valid_q[k-1];
            if (valid_q[k-1]) begin
               data_d[k] = data_q[k-1];
               inv_d[k]  = inv_q[k-1];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         inv_q   <= '0;
         for (int k = 0; k < PIPE_DEPTH; k++) begin
            data_q[k] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         inv_q   <= inv_d;
         for (int k = 0; k < PIPE_DEPTH; k++) begin
            data_q[k] <= data_d[k];
         end
      end
   end

   assign in_ready  = load[0];
   assign out_valid = valid_q[PIPE_DEPTH-1];
   assign out_data  = data_q[PIPE_DEPTH-1];
   assign out_inv   = inv_q[PIPE_DEPTH-1];
   assign busy      = |valid_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_row_shift_pipe.sv
// Bench for aes_row_shift_pipe: three instances (NB4/PD1, NB8/PD2, NB6/PD3) against a byte-matrix model.
`default_nettype none

module tb_aes_row_shift_pipe;

   typedef logic [256:0] ent_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         a_in_valid = 0, a_in_ready, a_in_inv = 0, a_out_valid, a_out_ready = 1, a_out_inv, a_busy;
   logic [127:0] a_in_data = '0, a_out_data;
   logic         b_in_valid = 0, b_in_ready, b_in_inv = 0, b_out_valid, b_out_ready = 1, b_out_inv, b_busy;
   logic [255:0] b_in_data = '0, b_out_data;
   logic         c_in_valid = 0, c_in_ready, c_in_inv = 0, c_out_valid, c_out_ready = 1, c_out_inv, c_busy;
   logic [191:0] c_in_data = '0, c_out_data;

   aes_row_shift_pipe #(.NB(4), .PIPE_DEPTH(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .in_inv(a_in_inv), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .out_inv(a_out_inv), .busy(a_busy));
   aes_row_shift_pipe #(.NB(8), .PIPE_DEPTH(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .in_inv(b_in_inv), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .out_inv(b_out_inv), .busy(b_busy));
   aes_row_shift_pipe #(.NB(6), .PIPE_DEPTH(3)) dut_c (
      .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
      .in_inv(c_in_inv), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
      .out_inv(c_out_inv), .busy(c_busy));

   int n_checks = 0;
   int n_fail   = 0;
   int pops_c   = 0;
   ent_t qa[$], qb[$], qc[$];

   task automatic chk(string name, logic [255:0] got, logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, got, exp);
      end
   endtask

   // State as a 4 x nb byte matrix; forward reads row r from column c+sh, inverse writes there.
   function automatic logic [255:0] shift_model(int nb, logic inv, logic [255:0] din);
      logic [7:0]   s [4][8];
      logic [7:0]   t [4][8];
      int           sh [4];
      logic [255:0] dout;
      sh = '{0, 1, (nb == 8) ? 3 : 2, (nb == 8) ? 4 : 3};
      dout = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < nb; c++)
            s[r][c] = din[32*nb-1-8*(r+4*c) -: 8];
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < nb; c++)
            if (!inv) t[r][c] = s[r][(c + sh[r]) % nb];
            else      t[r][(c + sh[r]) % nb] = s[r][c];
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < nb; c++)
            dout[32*nb-1-8*(r+4*c) -: 8] = t[r][c];
      return dout;
   endfunction

   function automatic ent_t expect_of(int nb, logic inv, logic [255:0] din);
`ifdef ROW_SHIFT_INV_EN
      return {inv, shift_model(nb, inv, din)};
`else
      return {1'b0, shift_model(nb, 1'b0, din)};
`endif
   endfunction

   task automatic sb(string tag, int pd, int qsize, ent_t front, logic ir, logic ov, logic orr,
                     logic [255:0] od, logic oi, logic bz);
      chk({tag, " in_ready"}, {255'b0, ir}, {255'b0, (qsize < pd) || orr});
      chk({tag, " busy"}, {255'b0, bz}, {255'b0, qsize != 0});
      if (ov) begin
         if (qsize == 0) chk({tag, " out_valid with no beat in flight"}, {255'b0, ov}, '0);
         else begin
            chk({tag, " out_data"}, od, front[255:0]);
            chk({tag, " out_inv"}, {255'b0, oi}, {255'b0, front[256]});
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         qa.delete(); qb.delete(); qc.delete();
      end else begin
         sb("A", 1, qa.size(), (qa.size() != 0) ? qa[0] : '0, a_in_ready, a_out_valid, a_out_ready,
            {128'b0, a_out_data}, a_out_inv, a_busy);
         if (a_out_valid && a_out_ready && qa.size() != 0) void'(qa.pop_front());
         if (a_in_valid && a_in_ready) qa.push_back(expect_of(4, a_in_inv, {128'b0, a_in_data}));

         sb("B", 2, qb.size(), (qb.size() != 0) ? qb[0] : '0, b_in_ready, b_out_valid, b_out_ready,
            b_out_data, b_out_inv, b_busy);
         if (b_out_valid && b_out_ready && qb.size() != 0) void'(qb.pop_front());
         if (b_in_valid && b_in_ready) qb.push_back(expect_of(8, b_in_inv, b_in_data));

         sb("C", 3, qc.size(), (qc.size() != 0) ? qc[0] : '0, c_in_ready, c_out_valid, c_out_ready,
            {64'b0, c_out_data}, c_out_inv, c_busy);
         if (c_out_valid && c_out_ready && qc.size() != 0) begin
            void'(qc.pop_front());
            pops_c++;
         end
         if (c_in_valid && c_in_ready) qc.push_back(expect_of(6, c_in_inv, {64'b0, c_in_data}));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rst_chk(string tag, logic ov, logic [255:0] od, logic oi, logic bz);
      chk({tag, " reset out_valid"}, {255'b0, ov}, '0);
      chk({tag, " reset out_data"}, od, '0);
      chk({tag, " reset out_inv"}, {255'b0, oi}, '0);
      chk({tag, " reset busy"}, {255'b0, bz}, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [191:0] bp [5];
      logic         bpi [5];
      int           idx, pops0, vcount;
      logic         took;

      // Reset state
      #3;
      rst_chk("A", a_out_valid, {128'b0, a_out_data}, a_out_inv, a_busy);
      rst_chk("B", b_out_valid, b_out_data, b_out_inv, b_busy);
      rst_chk("C", c_out_valid, {64'b0, c_out_data}, c_out_inv, c_busy);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      chk("A in_ready after reset", {255'b0, a_in_ready}, 256'd1);
      chk("C in_ready after reset", {255'b0, c_in_ready}, 256'd1);

      // FIPS-197 App. B round 1 ShiftRows
      a_in_valid = 1; a_in_inv = 0; a_in_data = 128'hd42711aee0bf98f1b8b45de51e415230;
      tick();
      a_in_valid = 0;
      chk("A fips fwd out_valid", {255'b0, a_out_valid}, 256'd1);
      chk("A fips fwd out_data", {128'b0, a_out_data}, {128'b0, 128'hd4bf5d30e0b452aeb84111f11e2798e5});
      tick();

      // Inverse request
      a_in_valid = 1; a_in_inv = 1; a_in_data = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
      tick();
      a_in_valid = 0; a_in_inv = 0;
`ifdef ROW_SHIFT_INV_EN
      chk("A inv out_data", {128'b0, a_out_data}, {128'b0, 128'hd42711aee0bf98f1b8b45de51e415230});
      chk("A inv out_inv", {255'b0, a_out_inv}, 256'd1);
`else
      chk("A inv-disabled out_data", {128'b0, a_out_data}, {128'b0, 128'hd4b411e5e0419830b8275dae1ebf52f1});
      chk("A inv-disabled out_inv", {255'b0, a_out_inv}, 256'd0);
`endif
      tick();

      // NB = 8 with byte k = k
      for (int k = 0; k < 32; k++) b_in_data[255-8*k -: 8] = 8'(k);
      b_in_valid = 1; b_in_inv = 0;
      tick();
      b_in_valid = 0;
      tick();
      chk("B nb8 out_valid latency", {255'b0, b_out_valid}, 256'd1);
      chk("B nb8 out byte 2", {248'b0, b_out_data[255-16 -: 8]}, 256'h0e);
      chk("B nb8 out byte 3", {248'b0, b_out_data[255-24 -: 8]}, 256'h13);
      tick();

      // Continuous flow, 100 beats
      vcount = 0;
      for (int i = 0; i < 100; i++) begin
         b_in_valid = 1;
         for (int w = 0; w < 8; w++) b_in_data[32*w +: 32] = $urandom;
         b_in_inv = 1'($urandom_range(0, 1));
         tick();
         if (i >= 1 && b_out_valid) vcount++;
      end
      b_in_valid = 0; b_in_inv = 0;
      tick();
      if (b_out_valid) vcount++;
      chk("B stream outputs per cycle", 256'(vcount), 256'd100);
      tick();
      chk("B drained", {255'b0, b_out_valid}, 256'd0);

      // Backpressure on the 3-deep instance
      for (int i = 0; i < 5; i++) begin
         bp[i]  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         bpi[i] = 1'($urandom_range(0, 1));
      end
      c_out_ready = 0; idx = 0;
      for (int cyc = 0; cyc < 8; cyc++) begin
         c_in_valid = (idx < 5);
         c_in_data  = bp[(idx < 5) ? idx : 0];
         c_in_inv   = bpi[(idx < 5) ? idx : 0];
         @(negedge clk);
         took = c_in_valid && c_in_ready;
         tick();
         if (took) idx++;
      end
      chk("C accepted while stalled", 256'(idx), 256'd3);
      chk("C in_ready when full", {255'b0, c_in_ready}, 256'd0);
      pops0 = pops_c;
      c_out_ready = 1;
      for (int cyc = 0; cyc < 30 && (idx < 5 || qc.size() != 0); cyc++) begin
         c_in_valid = (idx < 5);
         c_in_data  = bp[(idx < 5) ? idx : 0];
         c_in_inv   = bpi[(idx < 5) ? idx : 0];
         @(negedge clk);
         took = c_in_valid && c_in_ready;
         tick();
         if (took) idx++;
      end
      c_in_valid = 0;
      chk("C all beats accepted", 256'(idx), 256'd5);
      chk("C beats emitted", 256'(pops_c - pops0), 256'd5);

      // Reset with two beats in flight
      c_out_ready = 0;
      c_in_valid = 1; c_in_data = {6{32'hA5C3_0F1E}}; c_in_inv = 1;
      tick();
      c_in_data = {6{32'h5A3C_F0E1}}; c_in_inv = 0;
      tick();
      c_in_valid = 0;
      tick();
      chk("C out_valid before reset", {255'b0, c_out_valid}, 256'd1);
      #2;
      rst_n = 1'b0;
      #1;
      rst_chk("C mid-stream", c_out_valid, {64'b0, c_out_data}, c_out_inv, c_busy);
      @(posedge clk); #1;
      rst_n = 1'b1;
      c_out_ready = 1;
      chk("C in_ready after mid reset", {255'b0, c_in_ready}, 256'd1);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("C no stale beat after reset", {255'b0, c_out_valid}, 256'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
